svga_scan_timing_gen: RTL
=========================

// Module: svga_scan_timing_gen
// PURPOSE
//  Parametrised VGA/SVGA raster timing generator; successor to the fixed 640x480 timing block.
//  Produces sync, blank, border, text-cell and graphics addressing for the video fetch pipeline.
//  Fetch coordinates lead the visible window by DECODE_DELAY clocks so the VRAM/font/palette
//  pipeline lands on time. Every counter runs in the pixel_clock domain; nothing is clocked from h_synch.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, in pixels
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, in lines
//  HS_POL 1, VS_POL 1   : asserted sync level
//  WIN_X 64, WIN_Y 48, WIN_W 512, WIN_H 384 : emulated-screen window within the active area
//  DECODE_DELAY 7       : fetch lead, in clocks
//  CELL_W 8, CELL_H 12  : character cell size, in source pixels
//  X_SCALE 2, Y_SCALE 2 : pixel/line replication factors
//  GRAPH_X_REP 1, GRAPH_Y_REP 3 : display pixels per graph column / display lines per graph row
//  BLINK_FRAMES 16      : frames per blink half-period (optional feature only)
// PORTS (HW=clog2(H_TOTAL), VW=clog2(V_TOTAL); SPW/SLW/CCW/CLW/GCW/GRW sized to their maximum values)
//  pixel_clock   in   1   pixel clock
//  reset_n       in   1   asynchronous active-low reset
//  h_synch       out  1   horizontal sync, level HS_POL when asserted
//  v_synch       out  1   vertical sync, level VS_POL when asserted
//  blank         out  1   high outside the active area
//  pixel_count   out  HW  0..H_TOTAL-1
//  line_count    out  VW  0..V_TOTAL-1
//  show_border   out  1   high outside the window
//  line_start    out  1   1-clk pulse at pixel_count==0
//  frame_start   out  1   1-clk pulse at pixel 0 of line 0
//  subchar_pixel out  SPW 0..CELL_W*X_SCALE-1
//  char_column   out  CCW character column
//  subchar_line  out  SLW 0..CELL_H*Y_SCALE-1
//  char_line     out  CLW character row
//  graph_col     out  GCW graphics column
//  graph_row     out  GRW graphics row
//  blink         out  1   blink phase
// BEHAVIOUR
//  - All outputs are registered and aligned to the pixel_count/line_count values of the same cycle.
//  - pixel_count wraps at H_TOTAL-1. line_count increments when pixel_count==H_TOTAL-1 and wraps at V_TOTAL-1.
//  - h_synch asserted for pixel_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; v_synch likewise per line.
//  - blank = (pixel_count>=H_ACTIVE)|(line_count>=V_ACTIVE).
//  - show_border = 0 only when both pixel and line lie inside the window; otherwise 1, including during blanking.
//  - Fetch span: pixel_count in [WIN_X-DECODE_DELAY, WIN_X+WIN_W-1-DECODE_DELAY] on a window line.
//  - Horizontal advance, once per fetch-span clock:
//    - subchar_pixel increments and wraps at CELL_W*X_SCALE-1; char_column +1 on that wrap.
//    - graph_col +1 every GRAPH_X_REP clocks.
//    - All three reset to 0 at line_start.
//  - Vertical advance at pixel_count==H_TOTAL-1 of each window line:
//    - subchar_line wraps at CELL_H*Y_SCALE-1; char_line +1 on that wrap.
//    - graph_row +1 every GRAPH_Y_REP lines.
//    - All three reset to 0 at the last pixel of line V_TOTAL-1, so they read 0 on line 0.
//  - Counters outside the fetch span or window hold their values. Window counters never wrap beyond their maxima.
//  - Reset values: every counter 0; h_synch=~HS_POL; v_synch=~VS_POL; blank=0; show_border=1; pulses=0; blink=0.
//  - Reset asserted mid-frame returns every output to its reset value at once. The first clock after release shows pixel 0 of line 0 with no pulses.
//  - Elaboration $error if WIN_X<DECODE_DELAY, WIN_X+WIN_W>H_ACTIVE, WIN_Y+WIN_H>V_ACTIVE, or any scale/rep is 0.
// CONFIGURATION
//  VGA_TIMING_BLINK_EN defined: a frame counter toggles blink on every BLINK_FRAMES-th frame_start.
//  VGA_TIMING_BLINK_EN undefined: blink is tied to 0 and no counter is built.
// STRUCTURE
//  svga_timing_pkg holds:
//  - mode constant sets for 640x480, 800x600 and 1024x768;
//  - H_TOTAL/V_TOTAL derivation functions;
//  - a clog2 width helper.
//  Sub-module svga_axis_counter (count, wrap, sync and blank compare, window compare) is instantiated once for H and once for V.
// TESTING
//  1 Defaults, release reset: frame_start every 420000 clks; h_synch=1 at pixels 656..751 only; v_synch=1 at lines 490..491 only.
//  2 Blanking: blank rises at pixel 640 of line 0 and falls at pixel 0 of line 1; blank=1 for all of lines 480..524.
//  3 Text: on line 48, subchar_pixel=0 at pixel 57, 1 at 58, char_column=1 at 73 and 31 at 553. Line 72 reads char_line=1; line 431 reads char_line=15, subchar_line=23.
//  4 Graphics: lines 48-50 read graph_row=0 and line 51 reads 1; graph_col=511 at pixel 568. show_border=0 for pixels 64..575 on lines 48..431 only.
//  5 Pull reset_n low at pixel 300 of line 100: every output takes its reset value immediately; after release counting restarts from 0,0.
//  6 VGA_TIMING_BLINK_EN with BLINK_FRAMES=2: blink toggles at every 2nd frame_start. Macro undefined: blink stays 0.

Source files
------------

// File: rtl/svga_timing_pkg.sv
// Shared raster timing definitions: standard mode sets, total-count derivation and a width helper.
package svga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } mode_t;

  localparam mode_t MODE_640X480 = '{
    h_active: 640,  h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480,  v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0,   vs_pol: 1'b0
  };

  localparam mode_t MODE_800X600 = '{
    h_active: 800,  h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600,  v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  localparam mode_t MODE_1024X768 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    hs_pol: 1'b0,   vs_pol: 1'b0
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned h_total(input mode_t m);
    return axis_total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
  endfunction

  function automatic int unsigned v_total(input mode_t m);
    return axis_total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
  endfunction

  // Bits needed to hold the values 0..count-1, never less than one.
  function automatic int unsigned bits_for(input int unsigned count);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < count)) w++;
    return w;
  endfunction

endpackage

// File: rtl/svga_axis_counter.sv
// One raster axis: position counter with wrap, plus sync, active and window decodes of the
// position the counter is about to take, so the caller can register them aligned to it.
module svga_axis_counter
  import svga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned WIN_START  = 64,
  parameter int unsigned WIN_LEN    = 512,
  localparam int unsigned CW        = bits_for(TOTAL)
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          last,
  output logic          sync_nxt,
  output logic          outside_nxt,
  output logic          window_nxt
);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_START + SYNC_LEN - 1);
  localparam logic [CW-1:0] WIN_FIRST  = CW'(WIN_START);
  localparam logic [CW-1:0] WIN_LAST   = CW'(WIN_START + WIN_LEN - 1);

  assign last      = (count == LAST);
  assign count_nxt = !advance ? count : (last ? '0 : count + CW'(1));

  assign sync_nxt    = (count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST);
  assign outside_nxt = (count_nxt >= ACT_END);
  assign window_nxt  = (count_nxt >= WIN_FIRST) && (count_nxt <= WIN_LAST);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_nxt;
  end

endmodule

// File: rtl/svga_scan_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with text-cell and graphics fetch addressing.
// Optional blink phase generator is built when VGA_TIMING_BLINK_EN is defined.
module svga_scan_timing_gen
  import svga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned WIN_X        = 64,
  parameter int unsigned WIN_Y        = 48,
  parameter int unsigned WIN_W        = 512,
  parameter int unsigned WIN_H        = 384,
  parameter int unsigned DECODE_DELAY = 7,
  parameter int unsigned CELL_W       = 8,
  parameter int unsigned CELL_H       = 12,
  parameter int unsigned X_SCALE      = 2,
  parameter int unsigned Y_SCALE      = 2,
  parameter int unsigned GRAPH_X_REP  = 1,
  parameter int unsigned GRAPH_Y_REP  = 3,
  parameter int unsigned BLINK_FRAMES = 16,
  localparam int unsigned H_TOTAL     = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL     = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned CHAR_PIX    = CELL_W * X_SCALE,
  localparam int unsigned CHAR_LINES  = CELL_H * Y_SCALE,
  localparam int unsigned HW          = bits_for(H_TOTAL),
  localparam int unsigned VW          = bits_for(V_TOTAL),
  localparam int unsigned SPW         = bits_for(CHAR_PIX),
  localparam int unsigned CCW         = bits_for(WIN_W / CHAR_PIX + 1),
  localparam int unsigned SLW         = bits_for(CHAR_LINES),
  localparam int unsigned CLW         = bits_for(WIN_H / CHAR_LINES + 1),
  localparam int unsigned GCW         = bits_for(WIN_W / GRAPH_X_REP + 1),
  localparam int unsigned GRW         = bits_for(WIN_H / GRAPH_Y_REP + 1)
) (
  input  logic           pixel_clock,
  input  logic           reset_n,
  output logic           h_synch,
  output logic           v_synch,
  output logic           blank,
  output logic [HW-1:0]  pixel_count,
  output logic [VW-1:0]  line_count,
  output logic           show_border,
  output logic           line_start,
  output logic           frame_start,
  output logic [SPW-1:0] subchar_pixel,
  output logic [CCW-1:0] char_column,
  output logic [SLW-1:0] subchar_line,
  output logic [CLW-1:0] char_line,
  output logic [GCW-1:0] graph_col,
  output logic [GRW-1:0] graph_row,
  output logic           blink
);

  if ((WIN_X < DECODE_DELAY) || (WIN_X + WIN_W > H_ACTIVE) || (WIN_Y + WIN_H > V_ACTIVE) ||
      (X_SCALE == 0) || (Y_SCALE == 0) || (GRAPH_X_REP == 0) || (GRAPH_Y_REP == 0) ||
      (BLINK_FRAMES == 0)) begin : g_bad_config
    $error("svga_scan_timing_gen: window exceeds active area, lead too long, or zero scale/rep");
  end

  localparam int unsigned GXW = bits_for(GRAPH_X_REP);
  localparam int unsigned GYW = bits_for(GRAPH_Y_REP);

  localparam logic [HW-1:0]  SPAN_FIRST = HW'(WIN_X - DECODE_DELAY);
  localparam logic [HW-1:0]  SPAN_LAST  = HW'(WIN_X + WIN_W - 1 - DECODE_DELAY);
  localparam logic [VW-1:0]  WIN_Y_FIRST = VW'(WIN_Y);
  localparam logic [VW-1:0]  WIN_Y_LAST  = VW'(WIN_Y + WIN_H - 1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(CHAR_PIX - 1);
  localparam logic [SLW-1:0] SL_LAST = SLW'(CHAR_LINES - 1);
  localparam logic [GXW-1:0] GX_LAST = GXW'(GRAPH_X_REP - 1);
  localparam logic [GYW-1:0] GY_LAST = GYW'(GRAPH_Y_REP - 1);
  localparam logic [CCW-1:0] CC_MAX  = CCW'(WIN_W / CHAR_PIX);
  localparam logic [CLW-1:0] CL_MAX  = CLW'(WIN_H / CHAR_LINES);
  localparam logic [GCW-1:0] GC_MAX  = GCW'(WIN_W / GRAPH_X_REP);
  localparam logic [GRW-1:0] GR_MAX  = GRW'(WIN_H / GRAPH_Y_REP);

  logic [HW-1:0] h_count_nxt;
  logic [VW-1:0] v_count_nxt;
  logic h_last, h_sync_nxt, h_outside_nxt, h_window_nxt;
  logic v_last, v_sync_nxt, v_outside_nxt, v_window_nxt;

  svga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC),
    .WIN_START(WIN_X), .WIN_LEN(WIN_W)
  ) u_h_axis (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .advance     (1'b1),
    .count       (pixel_count),
    .count_nxt   (h_count_nxt),
    .last        (h_last),
    .sync_nxt    (h_sync_nxt),
    .outside_nxt (h_outside_nxt),
    .window_nxt  (h_window_nxt)
  );

  svga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC),
    .WIN_START(WIN_Y), .WIN_LEN(WIN_H)
  ) u_v_axis (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .advance     (h_last),
    .count       (line_count),
    .count_nxt   (v_count_nxt),
    .last        (v_last),
    .sync_nxt    (v_sync_nxt),
    .outside_nxt (v_outside_nxt),
    .window_nxt  (v_window_nxt)
  );

  logic frame_nxt;
  logic window_line;
  logic fetch_span;

  assign frame_nxt   = (h_count_nxt == '0) && (v_count_nxt == '0);
  assign window_line = (line_count >= WIN_Y_FIRST) && (line_count <= WIN_Y_LAST);
  assign fetch_span  = window_line && (pixel_count >= SPAN_FIRST) && (pixel_count <= SPAN_LAST);

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_synch     <= ~HS_POL;
      v_synch     <= ~VS_POL;
      blank       <= 1'b0;
      show_border <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_synch     <= h_sync_nxt ? HS_POL : ~HS_POL;
      v_synch     <= v_sync_nxt ? VS_POL : ~VS_POL;
      blank       <= h_outside_nxt | v_outside_nxt;
      show_border <= ~(h_window_nxt & v_window_nxt);
      line_start  <= (h_count_nxt == '0);
      frame_start <= frame_nxt;
    end
  end

  // Horizontal fetch addressing: cleared entering pixel 0, advanced once per fetch-span clock.
  logic [GXW-1:0] gx_rep;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      subchar_pixel <= '0;
      char_column   <= '0;
      graph_col     <= '0;
      gx_rep        <= '0;
    end else if (h_last) begin
      subchar_pixel <= '0;
      char_column   <= '0;
      graph_col     <= '0;
      gx_rep        <= '0;
    end else if (fetch_span) begin
      if (subchar_pixel == SP_LAST) begin
        subchar_pixel <= '0;
        if (char_column != CC_MAX) char_column <= char_column + CCW'(1);
      end else begin
        subchar_pixel <= subchar_pixel + SPW'(1);
      end
      if (gx_rep == GX_LAST) begin
        gx_rep <= '0;
        if (graph_col != GC_MAX) graph_col <= graph_col + GCW'(1);
      end else begin
        gx_rep <= gx_rep + GXW'(1);
      end
    end
  end

  // Vertical fetch addressing: advanced at the end of each window line, cleared leaving the frame.
  logic [GYW-1:0] gy_rep;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      subchar_line <= '0;
      char_line    <= '0;
      graph_row    <= '0;
      gy_rep       <= '0;
    end else if (h_last) begin
      if (v_last) begin
        subchar_line <= '0;
        char_line    <= '0;
        graph_row    <= '0;
        gy_rep       <= '0;
      end else if (window_line) begin
        if (subchar_line == SL_LAST) begin
          subchar_line <= '0;
          if (char_line != CL_MAX) char_line <= char_line + CLW'(1);
        end else begin
          subchar_line <= subchar_line + SLW'(1);
        end
        if (gy_rep == GY_LAST) begin
          gy_rep <= '0;
          if (graph_row != GR_MAX) graph_row <= graph_row + GRW'(1);
        end else begin
          gy_rep <= gy_rep + GYW'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_BLINK_EN
  localparam int unsigned BFW = bits_for(BLINK_FRAMES);
  localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES - 1);

  logic [BFW-1:0] frame_cnt;

  // Toggle in the same cycle as the frame_start pulse that completes the half-period.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_nxt) begin
      if (frame_cnt == BF_LAST) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + BFW'(1);
      end
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule
